alu_multiply_sequencer: RTL and testbench

Iterative multiplier that sequences the shared arithmetic logic unit through a shift-and-add loop, producing a DATA_WIDTH-bit product and a truncation flag. It sits beside the execute stage and owns the ALU operand and function-code inputs while busy. Operands are captured on a start pulse. The result is held until the next accepted start.

---
 rtl/alu_multiply_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_alu_multiply_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_multiply_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_multiply_sequencer (with definitions package alu_defs_pkg)
//  Description : Shift-and-add multiplier that borrows the shared ALU for every
//                add. Compile with MUL_SIGNED_EN for two's-complement operands.
//  Revision    : 1.0 - initial release
// ============================================================================

package alu_defs_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int FUNC_WIDTH = 3;
    localparam logic [FUNC_WIDTH-1:0] FUNC_SET = 3'd0;
    localparam logic [FUNC_WIDTH-1:0] FUNC_ADD = 3'd1;
    localparam logic [FUNC_WIDTH-1:0] FUNC_SUB = 3'd2;
    localparam logic [FUNC_WIDTH-1:0] FUNC_ABS = 3'd3;
endpackage

module alu_multiply_sequencer
    import alu_defs_pkg::*;
(
    input  logic                  _clock,
    input  logic                  _reset,
    input  logic                  _start,
    input  logic [DATA_WIDTH-1:0] _multiplicand,
    input  logic [DATA_WIDTH-1:0] _multiplier,
    input  logic [DATA_WIDTH-1:0] _aluResult,
    output logic [DATA_WIDTH-1:0] aluValA,
    output logic [DATA_WIDTH-1:0] aluValB,
    output logic [FUNC_WIDTH-1:0] aluFuncCode,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] product,
    output logic                  truncated
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] c_LAST = CW'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DONE  = 3'd2;
`ifdef MUL_SIGNED_EN
    localparam logic [2:0] S_ABS_A = 3'd3;
    localparam logic [2:0] S_ABS_B = 3'd4;
    localparam logic [2:0] S_NEG   = 3'd5;
    localparam logic [DATA_WIDTH-1:0] c_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

    logic [2:0]            r_state;
    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_mplier;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [CW-1:0]         r_count;
    logic                  r_trunc;
    logic [DATA_WIDTH-1:0] r_product;
    logic                  r_truncated;
`ifdef MUL_SIGNED_EN
    logic                  r_negate;
`endif

    logic [DATA_WIDTH-1:0] w_accNext;
    logic                  w_truncNext;

    // ALU drive plus the next accumulator/truncation values for this cycle
    always_comb begin
        aluFuncCode = FUNC_SET;
        aluValA     = '0;
        aluValB     = '0;
        w_accNext   = r_acc;
        w_truncNext = r_trunc;
        case (r_state)
            S_RUN: begin
                aluFuncCode = FUNC_ADD;
                aluValA     = r_acc;
                aluValB     = r_mcand;
                if (r_mplier[0]) begin
                    w_accNext = _aluResult;
                    if (_aluResult < r_acc) w_truncNext = 1'b1;
                end
                // A set top bit about to leave mcand still has multiplier bits to meet
                if (r_mcand[DATA_WIDTH-1] && ((r_mplier >> 1) != '0)) w_truncNext = 1'b1;
            end
`ifdef MUL_SIGNED_EN
            S_ABS_A: begin
                aluFuncCode = FUNC_ABS;
                aluValA     = r_mcand;
            end
            S_ABS_B: begin
                aluFuncCode = FUNC_ABS;
                aluValA     = r_mplier;
            end
            S_NEG: begin
                if (r_negate) begin
                    aluFuncCode = FUNC_SUB;
                    aluValB     = r_acc;
                    w_accNext   = _aluResult;
                end
                // The most negative value is the only magnitude with the top bit set that fits
                if (r_acc[DATA_WIDTH-1] && !((r_acc == c_MIN) && r_negate)) w_truncNext = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge _clock) begin
        if (_reset) begin
            r_state     <= S_IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_count     <= '0;
            r_trunc     <= 1'b0;
            r_product   <= '0;
            r_truncated <= 1'b0;
`ifdef MUL_SIGNED_EN
            r_negate    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (_start) begin
                        r_mcand  <= _multiplicand;
                        r_mplier <= _multiplier;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_trunc  <= 1'b0;
`ifdef MUL_SIGNED_EN
                        r_negate <= _multiplicand[DATA_WIDTH-1] ^ _multiplier[DATA_WIDTH-1];
                        r_state  <= S_ABS_A;
`else
                        r_state  <= S_RUN;
`endif
                    end
                end
`ifdef MUL_SIGNED_EN
                S_ABS_A: begin
                    r_mcand <= _aluResult;
                    r_state <= S_ABS_B;
                end
                S_ABS_B: begin
                    r_mplier <= _aluResult;
                    r_state  <= S_RUN;
                end
                S_NEG: begin
                    r_acc       <= w_accNext;
                    r_trunc     <= w_truncNext;
                    r_product   <= w_accNext;
                    r_truncated <= w_truncNext;
                    r_state     <= S_DONE;
                end
`endif
                S_RUN: begin
                    r_acc    <= w_accNext;
                    r_trunc  <= w_truncNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                    if (r_count == c_LAST) begin
`ifdef MUL_SIGNED_EN
                        r_state     <= S_NEG;
`else
                        r_product   <= w_accNext;
                        r_truncated <= w_truncNext;
                        r_state     <= S_DONE;
`endif
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done      = (r_state == S_DONE);
    assign product   = r_product;
    assign truncated = r_truncated;

endmodule
`default_nettype wire

// File: tb/tb_alu_multiply_sequencer.sv
`default_nettype none
// Directed testbench for alu_multiply_sequencer with a behavioural shared ALU.
module tb_alu_multiply_sequencer;
    import alu_defs_pkg::*;

`ifdef MUL_SIGNED_EN
    localparam int LAT = DATA_WIDTH + 4;
    localparam int RUN_FIRST = 3;
`else
    localparam int LAT = DATA_WIDTH + 1;
    localparam int RUN_FIRST = 1;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [DATA_WIDTH-1:0] mcandIn = '0;
    logic [DATA_WIDTH-1:0] mplierIn = '0;
    logic [DATA_WIDTH-1:0] aluResult;
    logic [DATA_WIDTH-1:0] aluValA;
    logic [DATA_WIDTH-1:0] aluValB;
    logic [FUNC_WIDTH-1:0] aluFuncCode;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] product;
    logic                  truncated;

    int checks = 0;
    int errors = 0;

    alu_multiply_sequencer dut (
        ._clock       (clk),
        ._reset       (rst),
        ._start       (start),
        ._multiplicand(mcandIn),
        ._multiplier  (mplierIn),
        ._aluResult   (aluResult),
        .aluValA      (aluValA),
        .aluValB      (aluValB),
        .aluFuncCode  (aluFuncCode),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .truncated    (truncated)
    );

    always #5 clk = ~clk;

    always_comb begin
        aluResult = aluValB;
        case (aluFuncCode)
            FUNC_ADD: aluResult = aluValA + aluValB;
            FUNC_SUB: aluResult = aluValA - aluValB;
            FUNC_ABS: aluResult = aluValA[DATA_WIDTH-1] ? (~aluValA + 1'b1) : aluValA;
            default:  aluResult = aluValB;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts one multiply, waits (bounded) for done, checks result and timing.
    task automatic runOp(input string tag, input logic [DATA_WIDTH-1:0] a,
                         input logic [DATA_WIDTH-1:0] b, input logic [DATA_WIDTH-1:0] expProd,
                         input logic expTrunc, input int pulseAt);
        int cyc;
        int busyCnt;
        mcandIn = a;
        mplierIn = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mcandIn = 16'hDEAD;
        mplierIn = 16'hBEEF;
        cyc = 1;
        busyCnt = 0;
        check({tag, "_busy_c1"}, busy, 1'b1);
        while (done !== 1'b1 && cyc < 60) begin
            if (busy) busyCnt++;
            if (cyc == pulseAt) begin
                start = 1'b1;
                mcandIn = 16'h0007;
                mplierIn = 16'h0009;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, done, 1'b1);
        check({tag, "_latency"}, cyc, LAT);
        check({tag, "_busy_cycles"}, busyCnt, LAT - 1);
        check({tag, "_product"}, product, expProd);
        check({tag, "_trunc"}, truncated, expTrunc);
        @(posedge clk); #1;
        check({tag, "_done_single"}, done, 1'b0);
        check({tag, "_product_held"}, product, expProd);
    endtask

    initial begin
        int doneCnt;
        int busyCnt;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_product", product, 16'h0000);
        check("rst_trunc", truncated, 1'b0);
        check("rst_func", aluFuncCode, FUNC_SET);
        check("rst_valA", aluValA, 16'h0000);
        check("rst_valB", aluValB, 16'h0000);
        rst = 1'b0;
        @(posedge clk); #1;

        runOp("u3x5", 16'd3, 16'd5, 16'd15, 1'b0, 0);
        check("idle_func", aluFuncCode, FUNC_SET);
        runOp("u256x256", 16'h0100, 16'h0100, 16'h0000, 1'b1, 0);
        runOp("uFFFFx1", 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 0);
        runOp("u0xFFFF", 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 0);

        runOp("ignore", 16'h1234, 16'h0003, 16'h369C, 1'b0, 5);
        doneCnt = 0;
        busyCnt = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) doneCnt++;
            if (busy) busyCnt++;
        end
        check("ignore_no_extra_done", doneCnt, 0);
        check("ignore_no_extra_busy", busyCnt, 0);
        check("ignore_product", product, 16'h369C);

        mcandIn = 16'h00FF;
        mplierIn = 16'h0101;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (RUN_FIRST + 6) @(posedge clk);
        #1;
        check("mid_busy", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_product", product, 16'h0000);
        check("midrst_done", done, 1'b0);
        check("midrst_trunc", truncated, 1'b0);
        check("midrst_func", aluFuncCode, FUNC_SET);
        runOp("u7x6", 16'd7, 16'd6, 16'd42, 1'b0, 0);

`ifdef MUL_SIGNED_EN
        runOp("sm3x5", 16'hFFFD, 16'd5, 16'hFFF1, 1'b0, 0);
        runOp("sm4xm4", 16'hFFFC, 16'hFFFC, 16'd16, 1'b0, 0);
        runOp("s8000x1", 16'h8000, 16'h0001, 16'h8000, 1'b0, 0);
        runOp("s8000xm1", 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
